// File: rtl/wcs_loader.sv
// rtl/wcs_loader.sv - byte-stream loader for a writable control store (async SRAM)
module wcs_loader #(
    parameter int WIDTH  = 16,
    parameter int HEIGHT = 10,
    parameter int VERIFY = 1
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              start,
    input  logic [HEIGHT-1:0] base,
    input  logic [HEIGHT:0]   count,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [HEIGHT-1:0] a,
    output logic [WIDTH-1:0]  d,
    output logic              d_oe,
    input  logic [WIDTH-1:0]  q,
    output logic              cs_,
    output logic              we_,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [HEIGHT-1:0] err_addr
);

    localparam int NB = WIDTH / 8;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_COLLECT, S_SETUP, S_WRITE, S_HOLD,
        S_READ, S_CHECK, S_NEXT, S_DONE, S_ERR
    } state_t;

    state_t state, state_nx;

    logic [BW-1:0]     byte_cnt;
    logic [HEIGHT-1:0] addr;
    logic [HEIGHT:0]   remain;
    logic              xfer;
    logic              last_byte;
    logic              mismatch;
    logic              cs_nx, we_nx, d_oe_nx, in_ready_nx, busy_nx, done_nx;

    assign xfer      = (state == S_COLLECT) && in_valid && in_ready;
    assign last_byte = (byte_cnt == BW'(NB - 1));
    assign mismatch  = (q != d);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // RAM strobes are decoded from the next state and registered, so each
    // strobe is a clean flop output that matches the state it belongs to.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (start) state_nx = (count == '0) ? S_DONE : S_COLLECT;
            S_COLLECT: if (xfer && last_byte) state_nx = S_SETUP;
            S_SETUP:   state_nx = S_WRITE;
            S_WRITE:   state_nx = S_HOLD;
            S_HOLD:    state_nx = (VERIFY != 0) ? S_READ : S_NEXT;
            S_READ:    state_nx = S_CHECK;
            S_CHECK:   state_nx = mismatch ? S_ERR : S_NEXT;
            S_NEXT:    state_nx = (remain == (HEIGHT+1)'(1)) ? S_DONE : S_COLLECT;
            S_DONE:    state_nx = S_IDLE;
            S_ERR:     state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase

        cs_nx       = !(state_nx inside {S_SETUP, S_WRITE, S_HOLD, S_READ, S_CHECK});
        we_nx       = (state_nx != S_WRITE);
        d_oe_nx     = (state_nx inside {S_SETUP, S_WRITE, S_HOLD});
        in_ready_nx = (state_nx == S_COLLECT);
        busy_nx     = (state_nx inside {S_COLLECT, S_SETUP, S_WRITE, S_HOLD,
                                        S_READ, S_CHECK, S_NEXT});
        done_nx     = (state_nx == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cs_      <= 1'b1;
            we_      <= 1'b1;
            d_oe     <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            cs_      <= cs_nx;
            we_      <= we_nx;
            d_oe     <= d_oe_nx;
            in_ready <= in_ready_nx;
            busy     <= busy_nx;
            done     <= done_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            a        <= '0;
            d        <= '0;
            err      <= 1'b0;
            err_addr <= '0;
            byte_cnt <= '0;
            addr     <= '0;
            remain   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        err      <= 1'b0;
                        byte_cnt <= '0;
                        if (count != '0) begin
                            addr   <= base;
                            remain <= count;
                        end
                    end
                end
                S_COLLECT: begin
                    if (xfer) begin
                        d[int'(byte_cnt)*8 +: 8] <= in_data;
                        byte_cnt <= last_byte ? '0 : byte_cnt + BW'(1);
                        if (last_byte) a <= addr;
                    end
                end
                S_CHECK: begin
                    if (mismatch) begin
                        err      <= 1'b1;
                        err_addr <= a;
                    end
                end
                S_NEXT: begin
                    addr   <= addr + HEIGHT'(1);
                    remain <= remain - (HEIGHT+1)'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/wcs_loader.md
Name: wcs_loader

Overview:
- Writer-side counterpart to the bitslice microprogram ROMs.
- Fills a writable control store (an async SRAM with active-low chip select and write enable) from a byte stream.
- Each word is assembled from bytes and written with a 3-phase SRAM cycle. It is then read back and compared.
- Sits between a host/boot byte source and the control-store RAM; the sequencer later reads the RAM as it would a ROM.

Parameters:
- WIDTH, 16, control-store word width in bits; must be a multiple of 8.
- HEIGHT, 10, address width in bits (2^HEIGHT words).
- VERIFY, 1, 1 = read back and compare each word after writing; 0 = skip readback.

Ports:
- clk  input  1  system clock, rising edge.
- rst_  input  1  reset.
- start  input  1  one-cycle load request; sampled only in IDLE.
- base  input  HEIGHT  first control-store address; latched on start.
- count  input  HEIGHT+1  number of words to load, 0..2^HEIGHT; latched on start.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle.
- a  output  HEIGHT  RAM address.
- d  output  WIDTH  RAM write data.
- d_oe  output  1  drive d onto the RAM data bus.
- q  input  WIDTH  RAM read data.
- cs_  output  1  RAM chip select, active low.
- we_  output  1  RAM write enable, active low.
- busy  output  1  load in progress.
- done  output  1  one-cycle pulse on successful completion.
- err  output  1  sticky verify mismatch flag; cleared by next accepted start.
- err_addr  output  HEIGHT  address of the first mismatch.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- All state is updated on the rising edge of clk. rst_ low forces the reset values immediately, regardless of clk.
- Reset values: state=IDLE, a=0, d=0, d_oe=0, cs_=1, we_=1, in_ready=0, busy=0, done=0, err=0, err_addr=0; internal byte, word and address counters = 0.
- IDLE: accepts start. count=0 -> go to DONE next cycle, with no RAM access. Otherwise latch base/count, clear err, set busy, go to COLLECT.
- start is ignored whenever state is not IDLE.
- COLLECT: in_ready=1. A byte is transferred when in_valid and in_ready are both 1.
  - Bytes assemble little-endian: the first byte goes to d[7:0], the next to d[15:8], and so on.
  - After WIDTH/8 transfers go to SETUP. in_ready drops in the cycle after the last byte.
  - in_valid low stalls indefinitely, with no timeout.
- SETUP (1 cycle): cs_=0, we_=1, d_oe=1, a=current address.
- WRITE (1 cycle): cs_=0, we_=0. a and d are held stable.
- HOLD (1 cycle): cs_=0, we_=1, d_oe=1. a and d are held stable.
- After HOLD: VERIFY=1 -> READ; VERIFY=0 -> NEXT.
- READ (1 cycle): cs_=0, we_=1, d_oe=0, a unchanged.
- CHECK (1 cycle): q is sampled at the end of the cycle.
  - q != d -> err=1, err_addr=a, go to ERR.
  - q == d -> go to NEXT.
- NEXT (1 cycle): cs_=1. Address increments modulo 2^HEIGHT (wrap from all-ones to 0 is legal). Decrement the remaining-word count.
  - Remaining count = 0 -> DONE; otherwise -> COLLECT.
- DONE (1 cycle): done=1, busy=0, then IDLE.
- ERR (1 cycle): busy=0, no done pulse, then IDLE. err stays set until the next accepted start.
- cs_ and we_ outputs are registered, so no glitches. we_ is low only in WRITE. d_oe is never 1 while the RAM is in a read phase.
- Per-word latency with VERIFY=1 is 6 cycles after the last byte (SETUP..NEXT), and 4 with VERIFY=0.
- count=2^HEIGHT loads the whole store exactly once.
- Reset asserted mid-write aborts at once: we_ and cs_ go to 1 asynchronously and the partial word is discarded.

Test Plan:
- WIDTH=16, VERIFY=1, base=0x010, count=2, bytes 34 12 78 56, RAM model echoes writes -> writes 0x1234@0x010 and 0x5678@0x011; one we_ low pulse per word; done pulses once; err=0.
- Same as above with in_valid deasserted for 5 cycles between bytes 1 and 2 -> no RAM activity during the stall; identical final contents; in_ready stays 1 throughout.
- base=0x3FF, count=2 -> writes at 0x3FF, then 0x000 (wrap); done pulses.
- Inject stuck bit 0 at address 0x011 in the RAM model -> err=1, err_addr=0x011, no done pulse, busy=0; the next start clears err.
- count=0 with start -> done pulses 2 cycles later; cs_ never goes low; a start pulse while busy is ignored.
- rst_ asserted asynchronously during WRITE -> we_=1 and cs_=1 before the next clk edge; all outputs at reset values.
